// File: rtl/pwm_pkg.sv
// Shared types and limits for the multi-channel PWM block.
package pwm_pkg;
    localparam int CNT_W_MAX  = 32;
    localparam int NUM_CH_MAX = 16;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} pwm_state_e;
    typedef enum logic {UP = 1'b0, DOWN = 1'b1} pwm_dir_e;
endpackage

// File: rtl/pwm_cmp_ch.sv
// One PWM channel: active duty register, compare against the shared counter, registered output.
module pwm_cmp_ch #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upd,
    input  logic             run,
    input  logic [CNT_W-1:0] duty_new,
    input  logic [CNT_W-1:0] cnt,
    output logic             out
);
    logic [CNT_W-1:0] duty_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_act <= '0;
            out      <= 1'b0;
        end else begin
            if (upd) duty_act <= duty_new;
            out <= run && (cnt < duty_act);
        end
    end
endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with shared counter and shadowed period/duty.
// Centre-aligned up/down counting is built only when PWM_CENTER_ALIGN_EN is defined.
//
// state | meaning
// IDLE  | enable low: counter held 0, outputs low, pending loads applied at once
// RUN   | counting; shadow values move to active only at the cycle boundary
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [CNT_W-1:0]        period,
    input  logic [NUM_CH*CNT_W-1:0] duty,
    input  logic                    load,
    input  logic                    center_mode,
    output logic [NUM_CH-1:0]       out,
    output logic                    cycle_start,
    output logic                    upd_ack
);
    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_RUN  = RUN;

    logic [0:0]              state;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [CNT_W-1:0]        per_act, per_shd, per_new, per_last;
    logic [NUM_CH*CNT_W-1:0] duty_shd, duty_new;
    logic                    pending, run, run_cmp, upd_pt, upd, at_start;

`ifdef PWM_CENTER_ALIGN_EN
    pwm_dir_e dir, dir_nxt;
    logic     center_act;
`else
    logic     unused_center;
`endif

    assign run      = (state == S_RUN) && enable;
    assign run_cmp  = run && (per_act != '0);
    assign per_last = per_act - 1'b1;
    assign per_new  = load ? period : per_shd;
    assign duty_new = load ? duty : duty_shd;
    assign upd      = upd_pt && (pending || load);

    // A zero period parks the counter but keeps every cycle an update point so a load can escape it.
    always_comb begin
        cnt_nxt = '0;
        upd_pt  = (state == S_IDLE);
`ifdef PWM_CENTER_ALIGN_EN
        dir_nxt = UP;
`endif
        if (run) begin
            if (per_act == '0) begin
                upd_pt = 1'b1;
`ifdef PWM_CENTER_ALIGN_EN
            end else if (center_act && (dir == UP)) begin
                dir_nxt = (cnt == per_last) ? DOWN : UP;
                cnt_nxt = (cnt == per_last) ? cnt : cnt + 1'b1;
            end else if (center_act) begin
                if (cnt == '0) begin
                    upd_pt = 1'b1;
                end else begin
                    dir_nxt = DOWN;
                    cnt_nxt = cnt - 1'b1;
                end
`endif
            end else if (cnt == per_last) begin
                upd_pt = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    assign at_start = (cnt == '0) && (dir == UP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir        <= UP;
            center_act <= 1'b0;
        end else begin
            dir <= dir_nxt;
            if (upd_pt) center_act <= center_mode;
        end
    end
`else
    assign at_start      = (cnt == '0);
    assign unused_center = center_mode;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            per_act     <= '0;
            per_shd     <= '0;
            duty_shd    <= '0;
            pending     <= 1'b0;
            upd_ack     <= 1'b0;
            cycle_start <= 1'b0;
        end else begin
            state       <= enable ? S_RUN : S_IDLE;
            cnt         <= cnt_nxt;
            upd_ack     <= upd;
            cycle_start <= run_cmp && at_start;
            if (load) begin
                per_shd  <= period;
                duty_shd <= duty;
            end
            if (upd) begin
                per_act <= per_new;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_cmp_ch #(.CNT_W(CNT_W)) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .upd      (upd),
            .run      (run_cmp),
            .duty_new (duty_new[i*CNT_W +: CNT_W]),
            .cnt      (cnt),
            .out      (out[i])
        );
    end
endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: cycle-position reference model, directed scenarios plus random traffic.
module tb_pwm_multi;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic        center_mode = 1'b0;
    logic [7:0]  period = '0;
    logic [31:0] duty = '0;
    logic [3:0]  out;
    logic        cycle_start, upd_ack;

    pwm_multi #(.NUM_CH(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .period      (period),
        .duty        (duty),
        .load        (load),
        .center_mode (center_mode),
        .out         (out),
        .cycle_start (cycle_start),
        .upd_ack     (upd_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] o;
        logic       cs;
        logic       ack;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference state: position within the PWM cycle (0..len-1), not the counter itself.
    bit m_run, m_pend, m_ctr;
    int m_pos, m_p, m_sp;
    int m_d[4];
    int m_sd[4];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_ctr = 0; m_pos = 0; m_p = 0; m_sp = 0;
        for (int i = 0; i < 4; i++) begin
            m_d[i] = 0;
            m_sd[i] = 0;
        end
        q.delete();
    endtask

    task automatic model_edge();
        exp_t e;
        bit run, bnd, upd;
        int len, c;
        run = m_run && enable;
        len = m_ctr ? 2 * m_p : m_p;
        c   = (m_ctr && m_pos >= m_p) ? 2 * m_p - 1 - m_pos : m_pos;
        for (int i = 0; i < 4; i++) e.o[i] = run && (m_p > 0) && (c < m_d[i]);
        e.cs  = run && (m_p > 0) && (m_pos == 0);
        bnd   = !m_run || (run && (m_p == 0 || m_pos == len - 1));
        upd   = bnd && (m_pend || load);
        e.ack = upd;
        q.push_back(e);
        m_pos = (run && m_p > 0) ? (m_pos + 1) % len : 0;
        if (upd) begin
            m_p = load ? int'(period) : m_sp;
            for (int i = 0; i < 4; i++) m_d[i] = load ? int'(duty[i*8 +: 8]) : m_sd[i];
            m_pend = 0;
        end else if (load) begin
            m_pend = 1;
        end
        if (load) begin
            m_sp = period;
            for (int i = 0; i < 4; i++) m_sd[i] = duty[i*8 +: 8];
        end
`ifdef PWM_CENTER_ALIGN_EN
        if (bnd) m_ctr = center_mode;
`endif
        m_run = enable;
    endtask

    task automatic step(input bit en, input bit ld, input int per, input logic [31:0] dty, input bit cm);
        enable = en; load = ld; period = per[7:0]; duty = dty; center_mode = cm;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic hold(input bit en, input int n);
        for (int k = 0; k < n; k++) step(en, 0, period, duty, center_mode);
    endtask

    task automatic step_to_pos(input int target);
        int n = 0;
        while (m_pos != target && n < 300) begin
            step(enable, 0, period, duty, center_mode);
            n++;
        end
        check("reach_pos", m_pos, target);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && q.size() > 0) begin
                e = q.pop_front();
                check("out", out, e.o);
                check("cycle_start", cycle_start, e.cs);
                check("upd_ack", upd_ack, e.ack);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int ones[4];
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", out, 4'h0);
        check("rst_cycle_start", cycle_start, 1'b0);
        check("rst_upd_ack", upd_ack, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Loaded while idle, then run: ch0 never, ch1 3/10, ch2/3 always high.
        step(0, 1, 10, {8'd12, 8'd10, 8'd3, 8'd0}, 0);
        hold(1, 12);
        for (int i = 0; i < 4; i++) ones[i] = 0;
        for (int k = 0; k < 20; k++) begin
            step(1, 0, period, duty, 0);
            for (int i = 0; i < 4; i++) ones[i] += out[i];
        end
        check("ch0_high_count", ones[0], 0);
        check("ch1_high_count", ones[1], 6);
        check("ch2_high_count", ones[2], 20);
        check("ch3_high_count", ones[3], 20);

        // Mid-cycle reload is deferred to the wrap.
        step(1, 1, 10, {4{8'd3}}, 0);
        hold(1, 12);
        step_to_pos(5);
        step(1, 1, 10, {4{8'd7}}, 0);
        hold(1, 25);

        // Load exactly on the wrap edge, then two loads within one cycle.
        step_to_pos(9);
        step(1, 1, 10, {4{8'd5}}, 0);
        hold(1, 12);
        step_to_pos(2);
        step(1, 1, 10, {4{8'd1}}, 0);
        step(1, 1, 10, {4{8'd8}}, 0);
        hold(1, 25);

        // Zero period parks everything low until a real period is loaded.
        step_to_pos(0);
        step(1, 1, 0, {4{8'd2}}, 0);
        hold(1, 15);
        step(1, 1, 4, {4{8'd2}}, 0);
        hold(1, 10);
        step_to_pos(2);
        hold(0, 5);

`ifdef PWM_CENTER_ALIGN_EN
        step(0, 1, 8, {4{8'd3}}, 1);
        hold(1, 20);
        ones[0] = 0;
        for (int k = 0; k < 32; k++) begin
            step(1, 0, period, duty, 1);
            ones[0] += out[0];
        end
        check("center_high_count", ones[0], 12);
        hold(0, 3);
`endif

        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(0, 19) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 12),
                 {8'($urandom_range(0, 14)), 8'($urandom_range(0, 14)),
                  8'($urandom_range(0, 14)), 8'($urandom_range(0, 14))},
                 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset while outputs are high.
        step(0, 1, 5, {4{8'd12}}, 0);
        hold(1, 10);
        check("pre_reset_out", out, 4'hf);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", out, 4'h0);
        check("async_rst_cycle_start", cycle_start, 1'b0);
        check("async_rst_upd_ack", upd_ack, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        hold(1, 5);
        for (int k = 0; k < 200; k++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9),
                 $urandom(), 1'($urandom_range(0, 1)));
        end
        hold(0, 2);
        @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
